encoder8_3: RTL and testbench
=============================

# encoder8_3

Registered 8-to-3 priority encoder with event capture and a valid/ready output. It is the inverse of the team's 3-to-8 decoder. Rising edges on eight request lines are latched as pending events. The highest-priority pending index is presented as a 3-bit code, held until the consumer accepts it, and then cleared. It sits between raw request/strobe lines (keys, decoder outputs, interrupt sources) and any downstream consumer that handles one index at a time.

## Interface
- PRIO_MSB, 1, 1: bit 7 has highest priority; 0: bit 0 has highest priority.
- sys_clk  in  1  single clock; all state updates on rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- in  in  8  request lines; level inputs, assumed already synchronous to sys_clk.
- out  out  3  encoded index of the presented event.
- out_valid  out  1  out holds a pending event.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready on a clock edge.
- pend_cnt  out  4  number of pending events, 0..8.
- overflow  out  1  one-cycle pulse: a new edge hit a bit that was already pending; the new edge is merged, not queued.

## Operation
- Input stage: in_r <= in and in_r2 <= in_r. edge = in_r & ~in_r2.
- Both in_r and in_r2 reset to 8'hFF, so lines held high through reset produce no event.
- Pending register, 8 bits: pending <= (pending & ~clr) | edge.
  - clr is onehot(out) on a transfer cycle, otherwise 0.
  - If an edge and a clear hit the same bit in the same cycle, the bit stays set; it counts as a new event.
- overflow <= |(edge & pending & ~clr). This is registered, so it pulses the cycle after the collision.
- pend_cnt <= popcount(pending_next). It always matches the pending register.
- FSM, two states:
  - IDLE: out_valid=0. If pending != 0, load out = prio(pending), set out_valid=1, go to HOLD.
  - HOLD: out_valid=1. out is stable while out_ready=0, even if a higher-priority edge arrives.
  - HOLD with out_ready=1: clear the bit at out. If (pending_next) != 0, reload out = prio(pending_next) and stay in HOLD, giving back-to-back transfers. Otherwise go to IDLE.
- prio(): the highest set index when PRIO_MSB=1, the lowest when PRIO_MSB=0. The result for an all-zero input is never used.
- Reset, sync, mid-operation: on the next edge every register returns to its reset value. Any pending event is discarded and no transfer completes.

## Timing
- Reset values:
  - out=3'd0, out_valid=0, pend_cnt=0, overflow=0.
  - pending=8'h00, in_r=in_r2=8'hFF, state IDLE.
- Latency: in rises and is first sampled at edge N.
  - in_r=1 at N and in_r2 still 0, so edge is high during cycle N.
  - pending is set at N+1, pend_cnt=1 at N+1.
  - out_valid=1 and out valid at N+2 when the FSM is in IDLE.
- Throughput: one transfer per cycle while pending is non-empty and out_ready=1.
- Pulse width: an input pulse of 1 cycle is captured. A line must fall, then rise again to log a second event.
- out_ready while out_valid=0 is ignored.

## Structure
- Package encoder_pkg holds:
  - localparams N_REQ=8, IDX_W=3, CNT_W=4.
  - typedef enum {IDLE, HOLD} enc_state_t.
- Sub-module prio_enc8: combinational, 8-bit in, 3-bit idx, parameter PRIO_MSB. It is instantiated twice: once on pending for the IDLE load and once on pending_next for the HOLD reload.
- Popcount is a local function; no further sub-modules.

## Test plan
- Reset with in=8'hFF held, release, hold 20 cycles: out_valid stays 0, pend_cnt=0.
- Single pulse in[5] at edge N, out_ready=1: out_valid=1 with out=3'd5 at N+2, transfer completes, out_valid=0 at N+3, pend_cnt returns to 0.
- in rises 8'b1001_0010 in one cycle, out_ready=0 for 5 cycles then 1:
  - With PRIO_MSB=1: out sequence 7,4,1 on consecutive cycles, pend_cnt 3→2→1→0.
  - With PRIO_MSB=0: out sequence 1,4,7.
- Backpressure: out=3 held with out_ready=0, then in[6] rises. out stays 3 until accepted, then 6 is presented on the next cycle. PRIO_MSB=1.
- Overflow: in[2] pulses, out_ready=0, in[2] pulses again 3 cycles later. overflow pulses for exactly 1 cycle, pend_cnt stays 1, only one transfer of 2 occurs.
- Same-cycle clear and re-edge on bit 0, plus reset mid-operation:
  - in[0] edge on the transfer cycle of index 0: a second transfer of index 0 follows.
  - sys_rst_n=0 for 1 cycle with 3 pending: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the registered 8-to-3 priority encoder.
//   N_REQ : number of request lines
//   IDX_W : width of the encoded index
//   CNT_W : width of the pending-event count (0..N_REQ)
package encoder_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE,
    HOLD
  } enc_state_t;

endpackage

// File: rtl/encoder8_3_prio_enc8.sv
// Combinational 8-bit priority encoder.
// Ports:
//   in  [7:0] : request vector
//   idx [2:0] : index of the winning set bit (0 when in is all-zero)
// Parameter:
//   PRIO_MSB  : 1 -> highest set index wins, 0 -> lowest set index wins
module prio_enc8
  import encoder_pkg::*;
#(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] idx
);

  // Scan order is chosen so the last hit is the winner.
  always_comb begin
    idx = '0;
    if (PRIO_MSB) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (in[i]) idx = i[IDX_W-1:0];
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (in[i]) idx = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/encoder8_3.sv
// Registered 8-to-3 priority encoder with rising-edge event capture and a
// valid/ready output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing presented; loads the winner of pending when non-empty
// HOLD  | out presented and held until accepted; reloads on accept
//
// Ports:
//   sys_clk    : clock, all state on the rising edge
//   sys_rst_n  : synchronous active-low reset
//   in[7:0]    : request lines, already synchronous to sys_clk
//   out[2:0]   : index of the presented event
//   out_valid  : out holds a pending event
//   out_ready  : consumer accept; transfer when out_valid && out_ready
//   pend_cnt   : number of pending events (0..8)
//   overflow   : one-cycle pulse when an edge hits an already-pending bit
module encoder8_3
  import encoder_pkg::*;
#(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow
);

  function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  enc_state_t       state, state_next;
  logic [N_REQ-1:0] in_r, in_r2;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] pending, pending_next;
  logic [N_REQ-1:0] clr;
  logic [IDX_W-1:0] out_next;
  logic [IDX_W-1:0] idx_cur, idx_nxt;
  logic             xfer;

  assign rise      = in_r & ~in_r2;
  assign out_valid = (state == HOLD);
  assign xfer      = out_valid && out_ready;
  assign clr       = xfer ? (N_REQ'(1) << out) : '0;
  // A re-edge on the bit being cleared wins, so it is logged as a new event.
  assign pending_next = (pending & ~clr) | rise;

  prio_enc8 #(.PRIO_MSB(PRIO_MSB)) u_prio_cur (
    .in  (pending),
    .idx (idx_cur)
  );

  prio_enc8 #(.PRIO_MSB(PRIO_MSB)) u_prio_nxt (
    .in  (pending_next),
    .idx (idx_nxt)
  );

  always_comb begin
    state_next = state;
    out_next   = out;
    case (state)
      IDLE: begin
        if (|pending) begin
          out_next   = idx_cur;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // While out_ready is low, out is frozen even if a better edge arrives.
        if (out_ready) begin
          if (|pending_next) out_next = idx_nxt;
          else               state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // in_r/in_r2 reset high so lines held high through reset raise no event.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      in_r     <= '1;
      in_r2    <= '1;
      pending  <= '0;
      pend_cnt <= '0;
      overflow <= 1'b0;
      out      <= '0;
      state    <= IDLE;
    end else begin
      in_r     <= in;
      in_r2    <= in_r;
      pending  <= pending_next;
      pend_cnt <= popcount(pending_next);
      overflow <= |(rise & pending & ~clr);
      out      <= out_next;
      state    <= state_next;
    end
  end

endmodule

// File: tb/tb_encoder8_3.sv
module tb_encoder8_3;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_req    = 8'hFF;

  logic [2:0] out_m, out_l;
  logic       vm, vl, om, ol;
  logic [3:0] cm, cl;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  encoder8_3 #(.PRIO_MSB(1'b1)) dut_msb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in        (in_req),
    .out       (out_m),
    .out_valid (vm),
    .out_ready (out_ready),
    .pend_cnt  (cm),
    .overflow  (om)
  );

  encoder8_3 #(.PRIO_MSB(1'b0)) dut_lsb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in        (in_req),
    .out       (out_l),
    .out_valid (vl),
    .out_ready (out_ready),
    .pend_cnt  (cl),
    .overflow  (ol)
  );

  typedef struct {
    logic [7:0] pattern;
    logic [2:0] exp_msb;
    logic [2:0] exp_lsb;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int bad;
    int n;
    int ovf_cycles;

    vecs[0] = '{8'h20, 3'd5, 3'd5, 4'd1};
    vecs[1] = '{8'h92, 3'd7, 3'd1, 4'd3};
    vecs[2] = '{8'h01, 3'd0, 3'd0, 4'd1};
    vecs[3] = '{8'h80, 3'd7, 3'd7, 4'd1};
    vecs[4] = '{8'hFF, 3'd7, 3'd0, 4'd8};
    vecs[5] = '{8'h18, 3'd4, 3'd3, 4'd2};
    vecs[6] = '{8'h41, 3'd6, 3'd0, 4'd2};

    // Reset with all lines held high
    step(2);
    chk("rst_out_m", out_m, 0);
    chk("rst_valid_m", vm, 0);
    chk("rst_cnt_m", cm, 0);
    chk("rst_ovf_m", om, 0);
    chk("rst_valid_l", vl, 0);
    sys_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vm || vl || cm != 0 || cl != 0) bad++;
    end
    chk("held_high_no_event", bad, 0);
    in_req = 8'h00;
    step(3);
    chk("fall_no_event", {vm, cm}, 0);

    // Single pulse on in[5] with out_ready already high
    out_ready = 1'b1;
    in_req = 8'h20;
    step();
    in_req = 8'h00;
    step();
    chk("pulse_cnt_n1", cm, 1);
    chk("pulse_valid_n1", vm, 0);
    step();
    chk("pulse_valid_n2", vm, 1);
    chk("pulse_out_n2", out_m, 5);
    step();
    chk("pulse_valid_n3", vm, 0);
    chk("pulse_cnt_n3", cm, 0);
    out_ready = 1'b0;
    step(2);

    // Table: capture a pattern, check winner, drain at one per cycle
    for (int v = 0; v < 7; v++) begin
      in_req = vecs[v].pattern;
      step(3);
      chk($sformatf("tbl%0d_valid", v), {vm, vl}, 2'b11);
      chk($sformatf("tbl%0d_out_msb", v), out_m, vecs[v].exp_msb);
      chk($sformatf("tbl%0d_out_lsb", v), out_l, vecs[v].exp_lsb);
      chk($sformatf("tbl%0d_cnt", v), cm, vecs[v].exp_cnt);
      in_req = 8'h00;
      out_ready = 1'b1;
      n = 0;
      while ((vm || vl) && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("tbl%0d_drain_cycles", v), n, vecs[v].exp_cnt);
      chk($sformatf("tbl%0d_drain_cnt", v), {cm, cl}, 0);
      out_ready = 1'b0;
      step(2);
    end

    // 1001_0010 held off 5 cycles, then consecutive transfers
    in_req = 8'h92;
    step();
    in_req = 8'h00;
    step(2);
    step(5);
    chk("seq_hold_out_m", out_m, 7);
    chk("seq_hold_out_l", out_l, 1);
    chk("seq_hold_cnt", cm, 3);
    out_ready = 1'b1;
    step();
    chk("seq_1_out_m", out_m, 4);
    chk("seq_1_out_l", out_l, 4);
    chk("seq_1_cnt", cm, 2);
    step();
    chk("seq_2_out_m", out_m, 1);
    chk("seq_2_out_l", out_l, 7);
    chk("seq_2_cnt", cm, 1);
    chk("seq_2_valid", {vm, vl}, 2'b11);
    step();
    chk("seq_3_valid", {vm, vl}, 0);
    chk("seq_3_cnt", {cm, cl}, 0);
    out_ready = 1'b0;
    step(2);

    // Backpressure: out=3 held while in[6] rises
    in_req = 8'h08;
    step();
    in_req = 8'h00;
    step(2);
    chk("bp_out_initial", out_m, 3);
    in_req = 8'h40;
    step();
    in_req = 8'h00;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_m != 3 || !vm) bad++;
    end
    chk("bp_out_held", bad, 0);
    chk("bp_cnt", cm, 2);
    out_ready = 1'b1;
    step();
    chk("bp_next_out", out_m, 6);
    chk("bp_next_valid", vm, 1);
    step();
    chk("bp_done_valid", vm, 0);
    out_ready = 1'b0;
    step(2);

    // Overflow: second pulse on in[2] while still pending
    in_req = 8'h04;
    step();
    in_req = 8'h00;
    step(2);
    in_req = 8'h04;
    step();
    in_req = 8'h00;
    ovf_cycles = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (om) ovf_cycles++;
      if (cm != 1) bad++;
    end
    chk("ovf_pulse_cycles", ovf_cycles, 1);
    chk("ovf_cnt_stays_1", bad, 0);
    chk("ovf_out", {vm, out_m}, {1'b1, 3'd2});
    out_ready = 1'b1;
    step();
    chk("ovf_one_xfer_valid", vm, 0);
    chk("ovf_one_xfer_cnt", cm, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (vm) bad++;
    end
    chk("ovf_no_second_xfer", bad, 0);
    out_ready = 1'b0;
    step(2);

    // Same-cycle clear and re-edge on bit 0
    in_req = 8'h01;
    step();
    in_req = 8'h00;
    step(2);
    chk("reedge_first_out", {vm, out_m}, {1'b1, 3'd0});
    in_req = 8'h01;
    step();
    out_ready = 1'b1;
    step();
    chk("reedge_second_valid", vm, 1);
    chk("reedge_second_out", out_m, 0);
    chk("reedge_cnt", cm, 1);
    chk("reedge_no_ovf", om, 0);
    in_req = 8'h00;
    step();
    chk("reedge_done_valid", vm, 0);
    chk("reedge_done_cnt", cm, 0);
    out_ready = 1'b0;
    step(2);

    // Reset mid-operation with three pending
    in_req = 8'h07;
    step();
    in_req = 8'h00;
    step(2);
    chk("midrst_pre_cnt", cm, 3);
    chk("midrst_pre_valid", vm, 1);
    sys_rst_n = 1'b0;
    step();
    chk("midrst_out", {out_m, out_l}, 0);
    chk("midrst_valid", {vm, vl}, 0);
    chk("midrst_cnt", {cm, cl}, 0);
    chk("midrst_ovf", {om, ol}, 0);
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (vm || vl || cm != 0) bad++;
    end
    chk("midrst_discarded", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
